// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit in front of the decoder.
//
// Keeps at most one request open to instruction memory. It buffers the
// returned words, each tagged with its PC, in a small FIFO and hands them to
// decode over a valid/ready interface. A redirect empties the FIFO, loads the
// new fetch PC, and drops any response that is still on its way.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned)
//   imem_gnt        memory accepts the request this cycle
//   imem_rvalid     response valid
//   imem_rdata      response instruction word
//   redirect        PC redirect pulse
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   ins_valid       head entry available to decode
//   ins_ready       decode consumes the head entry
//   ins, ins_pc     head instruction word and its PC (0 when empty)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no request open; waits for FIFO space
// S_REQ  | request presented at fetch_pc, waiting for grant
// S_WAIT | request granted, waiting for its response
// S_DROP | granted request made stale by a redirect; discard response

module ifu_fetch #(
   parameter int                   CPU_WIDTH = 64,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000),
   parameter int                   DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [CPU_WIDTH-1:0] imem_addr,
   input  logic                 imem_gnt,
   input  logic                 imem_rvalid,
   input  logic [31:0]          imem_rdata,
   input  logic                 redirect,
   input  logic [CPU_WIDTH-1:0] redirect_pc,
   output logic                 ins_valid,
   input  logic                 ins_ready,
   output logic [31:0]          ins,
   output logic [CPU_WIDTH-1:0] ins_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t               state;
   logic [CPU_WIDTH-1:0] fetch_pc;
   logic [CPU_WIDTH-1:0] issue_pc;
   logic [31:0]          word_q [DEPTH];
   logic [CPU_WIDTH-1:0] pc_q   [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [CW-1:0]        count;

   logic                 pop;
   logic                 push;
   logic                 space;
   logic [CW-1:0]        cnt_after;

   assign ins_valid = (count != '0);
   assign pop       = ins_valid && ins_ready;
   assign push      = (state == S_WAIT) && imem_rvalid && !redirect;
   // Space is judged on the current occupancy only; a pop happening in the
   // same cycle does not open a slot until the next cycle.
   assign space     = (count < DEPTH_C);

   always_comb begin
      cnt_after = count;
      if (push && !pop) begin
         cnt_after = count + CW'(1);
      end else if (pop && !push) begin
         cnt_after = count - CW'(1);
      end
   end

   // A redirect pulls the request down in the same cycle. The exception is a
   // cycle where memory grants: that request was already taken, so it stays
   // visible and its response is dropped later in S_DROP.
   assign imem_req  = (state == S_REQ) && !(redirect && !imem_gnt);
   assign imem_addr = fetch_pc;

   assign ins    = ins_valid ? word_q[rd_ptr] : '0;
   assign ins_pc = ins_valid ? pc_q[rd_ptr]   : '0;

   // Storage needs no reset; ins_valid masks stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr] <= imem_rdata;
         pc_q[wr_ptr]   <= issue_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         issue_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[CPU_WIDTH-1:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         case (state)
            S_REQ:   state <= imem_gnt    ? S_DROP : S_IDLE;
            S_WAIT:  state <= imem_rvalid ? S_IDLE : S_DROP;
            S_DROP:  state <= imem_rvalid ? S_IDLE : S_DROP;
            default: state <= S_IDLE;
         endcase
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= cnt_after;
         case (state)
            S_IDLE: begin
               if (space) begin
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (imem_gnt) begin
                  issue_pc <= fetch_pc;
                  fetch_pc <= fetch_pc + CPU_WIDTH'(4);
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state <= (cnt_after < DEPTH_C) ? S_REQ : S_IDLE;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
